// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Serial back end of the host link. Byte strobes from the frame sequencer
//   are queued in a small FIFO and shifted out on rs232_tx as 8N1 (or 8E1
//   when UART_TX_PARITY_EN is defined), LSB first.
//
//   Optional feature macro: UART_TX_PARITY_EN -- inserts an even parity bit
//   (XOR of the 8 data bits) between the last data bit and the stop bit(s).
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   txen       in   byte write strobe, one write per high cycle
//   txdb       in   [7:0] byte to queue, sampled when txen=1
//   rs232_tx   out  serial line, idle high
//   tx_busy    out  FIFO non-empty or a frame in progress (registered)
//   fifo_full  out  FIFO holds 2**FIFO_AW entries (registered)
//   tx_ovf     out  sticky: a write was dropped; cleared only by reset
//
// state   | meaning
// S_IDLE  | line high; pops the FIFO head and enters S_START when non-empty
// S_START | start bit (low), BAUD_DIV clocks
// S_DATA  | 8 data bits LSB first, BAUD_DIV clocks each
// S_PARITY| even parity bit, BAUD_DIV clocks (parity build only)
// S_STOP  | stop bit(s) high, STOP_BITS*BAUD_DIV clocks, then S_IDLE

module uart_tx_fifo #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 115200,
   parameter int BAUD_DIV  = CLK_FREQ / BAUD,
   parameter int FIFO_AW   = 3,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       txen,
   input  logic [7:0] txdb,
   output logic       rs232_tx,
   output logic       tx_busy,
   output logic       fifo_full,
   output logic       tx_ovf
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CNTW  = FIFO_AW + 1;
   localparam int CW    = $clog2(BAUD_DIV);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t              state, state_next;
   logic [7:0]          mem [DEPTH];
   logic [FIFO_AW-1:0]  wptr, rptr;
   logic [CNTW-1:0]     count, count_next;
   logic [CW-1:0]       cnt;
   logic [2:0]          idx;
   logic [7:0]          shreg;
   logic                pop, push, drop, full_c, bit_end, line_next;
`ifdef UART_TX_PARITY_EN
   logic                par;
`endif

   assign full_c  = (count == CNTW'(DEPTH));
   assign bit_end = (cnt == CW'(BAUD_DIV - 1));
   // A full FIFO still accepts a write on the edge that pops the head.
   assign push    = txen && (!full_c || pop);
   assign drop    = txen && full_c && !pop;
   assign count_next = count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      line_next  = 1'b1;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               state_next = S_START;
            end
         end
         S_START: begin
            line_next = 1'b0;
            if (bit_end) state_next = S_DATA;
         end
         S_DATA: begin
            line_next = shreg[0];
            if (bit_end && idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_next = S_PARITY;
`else
               state_next = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            line_next = par;
            if (bit_end) state_next = S_STOP;
         end
`endif
         S_STOP: begin
            line_next = 1'b1;
            if (bit_end && idx == 3'(STOP_BITS - 1)) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         rs232_tx  <= 1'b1;
         tx_busy   <= 1'b0;
         fifo_full <= 1'b0;
         tx_ovf    <= 1'b0;
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
      end else begin
         state     <= state_next;
         rs232_tx  <= line_next;
         tx_busy   <= (count_next != '0) || (state_next != S_IDLE);
         fifo_full <= (count_next == CNTW'(DEPTH));
         if (drop) tx_ovf <= 1'b1;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count     <= count_next;
      end
   end

   // Storage is not reset; the pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= txdb;
   end

   // Baud counter reloads on every state entry and at each bit boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (state == S_IDLE || state_next != state || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // idx counts data bits (wrapping to 0 after bit 7) and then stop bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg <= '0;
         idx   <= '0;
`ifdef UART_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else if (pop) begin
         shreg <= mem[rptr];
         idx   <= '0;
`ifdef UART_TX_PARITY_EN
         par   <= ^mem[rptr];
`endif
      end else if (bit_end && state == S_DATA) begin
         shreg <= {1'b0, shreg[7:1]};
         idx   <= idx + 3'd1;
      end else if (bit_end && state == S_STOP) begin
         idx   <= idx + 3'd1;
      end
   end

endmodule
